spin_vector_cache: RTL and testbench
====================================

# spin_vector_cache

Multi-slot spin-vector cache for the energy monitor. It holds up to NUM_SLOTS spin vectors, each indexed by a slot id, and passes a newly accepted vector straight through to the read port in the same cycle. For every accepted write it emits a registered flip report: the XOR mask against the previously cached vector for that slot and a popcount of the flipped bits. This report drives the incremental energy update downstream under valid/ready flow control.

## Interface
- DATAWIDTH, 256: spin vector width in bits.
- NUM_SLOTS, 4: number of cached vectors; at least 1, not required to be a power of 2.
- SLOTW, max(1,$clog2(NUM_SLOTS)): slot index width; derived, not overridden.
- CNTW, $clog2(DATAWIDTH+1): flip count width; derived.

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- en_i  in  1  enable; low synchronously clears all cached state and blocks writes.
- data_valid_i  in  1  write request valid.
- data_ready_o  out  1  write request ready.
- slot_i  in  SLOTW  target slot of the write.
- data_i  in  DATAWIDTH  spin vector to cache.
- rd_slot_i  in  SLOTW  slot selected on the read port.
- data_o  out  DATAWIDTH  read data for rd_slot_i, with same-cycle write bypass.
- data_cached_o  out  DATAWIDTH  pure cached content of rd_slot_i, without bypass.
- flip_valid_o  out  1  flip report valid.
- flip_ready_i  in  1  flip report accepted by the consumer.
- flip_slot_o  out  SLOTW  slot the report refers to.
- flip_mask_o  out  DATAWIDTH  old XOR new for that slot.
- flip_cnt_o  out  CNTW  popcount of flip_mask_o.
- flip_first_o  out  1  the write hit an empty slot (old value taken as all-zero).

## Operation
- Write handshake: hs = en_i & data_valid_i & data_ready_o.
- data_ready_o = en_i & (!flip_valid_o | flip_ready_i). This forms a single-entry output pipeline, so a report may drain and a new write may enter in the same cycle.
- On hs with slot_i < NUM_SLOTS:
  - cache[slot_i] <= data_i and slot_valid[slot_i] <= 1.
  - The report register loads flip_slot_o=slot_i and flip_mask_o = cache[slot_i] ^ data_i, using the pre-write value.
  - It also loads flip_cnt_o = popcount(mask) and flip_first_o = !slot_valid[slot_i], and sets flip_valid_o <= 1.
- On hs with slot_i >= NUM_SLOTS: the write is accepted and dropped. Cache is unchanged and no report is produced; flip_valid_o follows the normal drain rule.
- Report drain: flip_valid_o & flip_ready_i with no new hs clears flip_valid_o. Report fields keep their last values, so they are don't-care while invalid.
- Read port (combinational):
  - data_cached_o = cache[rd_slot_i].
  - data_o = data_i if hs and slot_i==rd_slot_i, else cache[rd_slot_i].
  - Both read 0 when rd_slot_i >= NUM_SLOTS.
- en_i low, synchronous: all cache entries <= 0, all slot_valid <= 0, flip_valid_o <= 0. data_ready_o is 0 in the same cycle, so no write can be accepted.
- Report fields are not cleared by en_i low.
- Popcount is an unsigned sum of DATAWIDTH bits. A CNTW-bit result never overflows; a full flip of 256 bits gives 256.

## Timing
- Reset (rst_ni low at an edge): cache all 0, slot_valid all 0, flip_valid_o=0, flip_slot_o=0, flip_mask_o=0, flip_cnt_o=0, flip_first_o=0. data_ready_o is 0 only while en_i is low.
- Reset wins over en_i and over any handshake in the same cycle. Reset mid-stream discards any pending report.
- Write latency: cache updated at the edge ending the hs cycle. data_cached_o reflects the new value from cycle k+1; data_o reflects it in cycle k via bypass.
- Report latency: 1 cycle. hs in cycle k gives flip_valid_o=1 in cycle k+1, held stable until flip_ready_i.
- Back-to-back writes to the same slot: the second write's mask compares against the first write's data, since the cache is updated before the next compare.
- Stalled report (flip_valid_o=1, flip_ready_i=0): data_ready_o=0. The cache and report stay frozen.
- flip_valid_o must not depend combinationally on flip_ready_i. data_ready_o may depend on it.

## Test plan
- Reset then en_i=1, write slot0=0x0F (DATAWIDTH=8) -> next cycle flip_valid_o=1, mask 0x0F, cnt 4, first=1. Then write slot0=0xF0 -> mask 0xFF, cnt 8, first=0.
- Same-cycle bypass: rd_slot_i=2, hs on slot2 with 0xA5 -> data_o=0xA5 and data_cached_o=0x00 that cycle; both read 0xA5 the next cycle.
- Backpressure: hold flip_ready_i=0 after a write -> data_ready_o=0 and report fields stable for 5 cycles. Raise flip_ready_i with data_valid_i=1 -> drain and new accept in the same cycle, with the new report the next cycle.
- en_i low for 1 cycle with a pending report and filled slots -> flip_valid_o=0, all slots read 0. The next write to a previously filled slot reports first=1.
- NUM_SLOTS=3, write slot_i=3 -> accepted (data_ready_o=1), no report, slots 0..2 unchanged.
- Random writes and ready toggling over 10k cycles against a reference model -> exact match on every report field and read port; cnt equals popcount(mask) each report.

Source files
------------

// File: rtl/spin_vector_cache_if.sv
// Write, read and flip-report signals of the spin-vector cache.
// The DUT connects through the slave modport; the producer/consumer side uses master.
interface spin_vector_cache_if #(
  parameter int DATAWIDTH = 256,
  parameter int NUM_SLOTS = 4
);
  localparam int SLOTW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNTW  = $clog2(DATAWIDTH + 1);

  logic                 en_i;
  logic                 data_valid_i;
  logic                 data_ready_o;
  logic [SLOTW-1:0]     slot_i;
  logic [DATAWIDTH-1:0] data_i;
  logic [SLOTW-1:0]     rd_slot_i;
  logic [DATAWIDTH-1:0] data_o;
  logic [DATAWIDTH-1:0] data_cached_o;
  logic                 flip_valid_o;
  logic                 flip_ready_i;
  logic [SLOTW-1:0]     flip_slot_o;
  logic [DATAWIDTH-1:0] flip_mask_o;
  logic [CNTW-1:0]      flip_cnt_o;
  logic                 flip_first_o;

  modport slave (
    input  en_i, data_valid_i, slot_i, data_i, rd_slot_i, flip_ready_i,
    output data_ready_o, data_o, data_cached_o,
           flip_valid_o, flip_slot_o, flip_mask_o, flip_cnt_o, flip_first_o
  );

  modport master (
    output en_i, data_valid_i, slot_i, data_i, rd_slot_i, flip_ready_i,
    input  data_ready_o, data_o, data_cached_o,
           flip_valid_o, flip_slot_o, flip_mask_o, flip_cnt_o, flip_first_o
  );
endinterface

// File: rtl/spin_vector_cache.sv
// Multi-slot spin-vector cache with same-cycle read bypass and a registered
// flip report (XOR mask + popcount against the previous vector of the slot).
module spin_vector_cache #(
  parameter int DATAWIDTH = 256,
  parameter int NUM_SLOTS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  spin_vector_cache_if.slave   bus
);
  localparam int SLOTW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNTW  = $clog2(DATAWIDTH + 1);

  logic [DATAWIDTH-1:0] cache_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_valid_q;

  logic                 flip_valid_q;
  logic [SLOTW-1:0]     flip_slot_q;
  logic [DATAWIDTH-1:0] flip_mask_q;
  logic [CNTW-1:0]      flip_cnt_q;
  logic                 flip_first_q;

  logic                 wr_ready;
  logic                 hs;
  logic                 wr_in_range;
  logic                 old_valid;
  logic [DATAWIDTH-1:0] old_data;
  logic [DATAWIDTH-1:0] rd_cached;
  logic [DATAWIDTH-1:0] flip_mask_d;
  logic [CNTW-1:0]      flip_cnt_d;

  // Single-entry output stage: a draining report frees the slot for a new write.
  always_comb begin
    wr_ready = bus.en_i & (~flip_valid_q | bus.flip_ready_i);
    hs       = bus.en_i & bus.data_valid_i & wr_ready;
  end

  // Slot lookups by compare rather than indexing, so out-of-range ids read 0.
  always_comb begin
    wr_in_range = 1'b0;
    old_valid   = 1'b0;
    old_data    = '0;
    rd_cached   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (bus.slot_i == SLOTW'(i)) begin
        wr_in_range = 1'b1;
        old_valid   = slot_valid_q[i];
        old_data    = cache_q[i];
      end
      if (bus.rd_slot_i == SLOTW'(i)) begin
        rd_cached = cache_q[i];
      end
    end
  end

  always_comb begin
    flip_mask_d = old_data ^ bus.data_i;
    flip_cnt_d  = '0;
    for (int j = 0; j < DATAWIDTH; j++) begin
      flip_cnt_d = flip_cnt_d + CNTW'(flip_mask_d[j]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cache_q[i] <= '0;
      end
      slot_valid_q <= '0;
      flip_valid_q <= 1'b0;
      flip_slot_q  <= '0;
      flip_mask_q  <= '0;
      flip_cnt_q   <= '0;
      flip_first_q <= 1'b0;
    end else if (!bus.en_i) begin
      // Report fields are left as-is; only validity is dropped.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cache_q[i] <= '0;
      end
      slot_valid_q <= '0;
      flip_valid_q <= 1'b0;
    end else if (hs && wr_in_range) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (bus.slot_i == SLOTW'(i)) begin
          cache_q[i]      <= bus.data_i;
          slot_valid_q[i] <= 1'b1;
        end
      end
      flip_valid_q <= 1'b1;
      flip_slot_q  <= bus.slot_i;
      flip_mask_q  <= flip_mask_d;
      flip_cnt_q   <= flip_cnt_d;
      flip_first_q <= ~old_valid;
    end else if (bus.flip_ready_i) begin
      flip_valid_q <= 1'b0;
    end
  end

  assign bus.data_ready_o  = wr_ready;
  assign bus.data_cached_o = rd_cached;
  assign bus.data_o        = (hs && wr_in_range && (bus.slot_i == bus.rd_slot_i)) ?
                             bus.data_i : rd_cached;
  assign bus.flip_valid_o  = flip_valid_q;
  assign bus.flip_slot_o   = flip_slot_q;
  assign bus.flip_mask_o   = flip_mask_q;
  assign bus.flip_cnt_o    = flip_cnt_q;
  assign bus.flip_first_o  = flip_first_q;
endmodule

// File: tb/tb_spin_vector_cache.sv
// Scoreboard bench for spin_vector_cache: directed scenarios then random traffic,
// checked against an array/queue reference model of the cache and report stream.
module tb_spin_vector_cache;
  localparam int DW = 8;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int CW = 4;

  typedef struct packed {
    logic [SW-1:0] slot;
    logic [DW-1:0] mask;
    logic [CW-1:0] cnt;
    logic          first;
  } rpt_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spin_vector_cache_if #(.DATAWIDTH(DW), .NUM_SLOTS(NS)) bus ();
  spin_vector_cache #(.DATAWIDTH(DW), .NUM_SLOTS(NS)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: what the cache holds and whether a report is owed.
  logic [DW-1:0] m_cache [NS];
  bit            m_valid [NS];
  bit            m_pend;
  rpt_t          exp_q [$];

  // Expected combinational outputs for the current cycle.
  logic          exp_ready, exp_fv;
  logic [DW-1:0] exp_data, exp_cached;
  bit            armed = 0;
  bit            rst_seen = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NS; i++) begin
      m_cache[i] = '0;
      m_valid[i] = 0;
    end
    m_pend = 0;
  endfunction

  task automatic step(input logic r, input logic e, input logic dv, input int s,
                      input logic [DW-1:0] d, input int rd, input logic fr);
    logic hs;
    logic [DW-1:0] old;
    rpt_t rp;
    @(posedge clk);
    #1;
    if (rst_seen) armed = 1;
    rst_n            = r;
    bus.en_i         = e;
    bus.data_valid_i = dv;
    bus.slot_i       = s[SW-1:0];
    bus.data_i       = d;
    bus.rd_slot_i    = rd[SW-1:0];
    bus.flip_ready_i = fr;

    exp_fv    = m_pend;
    exp_ready = e & (!m_pend | fr);
    hs        = e & dv & exp_ready;
    exp_cached = '0;
    if (rd < NS) exp_cached = m_cache[rd];
    exp_data = (hs && s == rd && rd < NS) ? d : exp_cached;

    if (!r || !e) begin
      model_clear();
    end else if (hs && s < NS) begin
      old      = m_cache[s];
      rp.slot  = s[SW-1:0];
      rp.mask  = old ^ d;
      rp.cnt   = CW'($countones(old ^ d));
      rp.first = !m_valid[s];
      exp_q.push_back(rp);
      m_cache[s] = d;
      m_valid[s] = 1;
      m_pend     = 1;
    end else if (fr) begin
      m_pend = 0;
    end
    if (!r) rst_seen = 1;
  endtask

  // Monitor: compares read port, ready and the presented report every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("data_ready", {31'b0, bus.data_ready_o}, {31'b0, exp_ready});
        chk("data_o", {24'b0, bus.data_o}, {24'b0, exp_data});
        chk("data_cached", {24'b0, bus.data_cached_o}, {24'b0, exp_cached});
        chk("flip_valid", {31'b0, bus.flip_valid_o}, {31'b0, exp_fv});
        if (exp_fv && bus.flip_valid_o) begin
          if (exp_q.size() == 0) begin
            chk("report_expected", 32'd0, 32'd1);
          end else begin
            chk("flip_slot", {30'b0, bus.flip_slot_o}, {30'b0, exp_q[0].slot});
            chk("flip_mask", {24'b0, bus.flip_mask_o}, {24'b0, exp_q[0].mask});
            chk("flip_cnt", {28'b0, bus.flip_cnt_o}, {28'b0, exp_q[0].cnt});
            chk("flip_first", {31'b0, bus.flip_first_o}, {31'b0, exp_q[0].first});
            chk("cnt_vs_mask", {28'b0, bus.flip_cnt_o}, 32'($countones(bus.flip_mask_o)));
            if (bus.flip_ready_i) void'(exp_q.pop_front());
          end
        end
        if (!rst_n || !bus.en_i) exp_q.delete();
      end
    end
  end

  initial begin
    int s;
    logic [DW-1:0] d;
    model_clear();
    rst_n = 1'b0;
    bus.en_i = 1'b0; bus.data_valid_i = 1'b0; bus.slot_i = '0;
    bus.data_i = '0; bus.rd_slot_i = '0; bus.flip_ready_i = 1'b0;

    step(0, 0, 0, 0, 8'h00, 0, 0);
    step(1, 0, 0, 0, 8'h00, 0, 0);
    @(negedge clk);
    chk("rst_slot", {30'b0, bus.flip_slot_o}, 32'd0);
    chk("rst_mask", {24'b0, bus.flip_mask_o}, 32'd0);
    chk("rst_cnt", {28'b0, bus.flip_cnt_o}, 32'd0);
    chk("rst_first", {31'b0, bus.flip_first_o}, 32'd0);

    // First write and full flip of slot 0
    step(1, 1, 1, 0, 8'h0F, 0, 0);
    step(1, 1, 0, 0, 8'h00, 0, 1);
    step(1, 1, 1, 0, 8'hF0, 0, 0);
    step(1, 1, 0, 0, 8'h00, 0, 1);
    // Same-cycle bypass on slot 2
    step(1, 1, 1, 2, 8'hA5, 2, 1);
    step(1, 1, 0, 0, 8'h00, 2, 1);
    // Backpressure: stalled report, then drain and accept together
    step(1, 1, 1, 1, 8'h3C, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 8'h55, 1, 0);
    step(1, 1, 1, 1, 8'hC3, 1, 1);
    step(1, 1, 0, 0, 8'h00, 1, 1);
    // Enable drop with a pending report and filled slots
    step(1, 1, 1, 0, 8'h11, 0, 0);
    step(1, 0, 1, 0, 8'h99, 0, 0);
    step(1, 1, 0, 0, 8'h00, 1, 0);
    step(1, 1, 0, 0, 8'h00, 2, 0);
    step(1, 1, 1, 0, 8'h22, 0, 1);
    step(1, 1, 0, 0, 8'h00, 0, 1);
    // Out-of-range slot is accepted and dropped
    step(1, 1, 1, 1, 8'h5A, 1, 1);
    step(1, 1, 1, 3, 8'h77, 3, 1);
    step(1, 1, 0, 0, 8'h00, 1, 1);
    step(1, 1, 0, 0, 8'h00, 3, 1);

    for (int n = 0; n < 10000; n++) begin
      s = int'($urandom_range(0, 3));
      d = 8'($urandom);
      if (s < NS && $urandom_range(0, 9) == 0) d = ~m_cache[s];
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 49) != 0),
           ($urandom_range(0, 9) < 7), s, d, int'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 6));
    end

    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 8'h00, 0, 1);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
